// File: rtl/access_controller.sv
// Door-access controller downstream of the password-lock FSM: turns unlocks into timed
// open windows, counts consecutive failures and enforces a timed lockout with an alarm pulse.
module access_controller #(
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16,
  localparam int FW = $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          unlock,
  input  logic          error,
  output logic          door_open,
  output logic          lockout,
  output logic          accept,
  output logic          alarm,
  output logic [FW-1:0] fail_cnt
);

  localparam int MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    LOCKED
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [FW-1:0]   fail_n;
  logic            unlock_d, error_d;
  logic            u_rise, e_rise;
  logic            door_open_n, lockout_n, accept_n, alarm_n;

  // Edge detectors track the inputs in every state so a level held across a window never retriggers.
  assign u_rise = unlock & ~unlock_d;
  assign e_rise = error & ~error_d;

  // State register; all outputs are registered from the next-state values.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      fail_cnt  <= '0;
      unlock_d  <= 1'b0;
      error_d   <= 1'b0;
      door_open <= 1'b0;
      lockout   <= 1'b0;
      alarm     <= 1'b0;
      accept    <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      fail_cnt  <= fail_n;
      unlock_d  <= unlock;
      error_d   <= error;
      door_open <= door_open_n;
      lockout   <= lockout_n;
      alarm     <= alarm_n;
      accept    <= accept_n;
    end
  end

  // Next-state logic; an error edge wins over a simultaneous unlock edge.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    timer_n = timer;
    fail_n  = fail_cnt;
    case (state)
      IDLE: begin
        if (e_rise) begin
          if (fail_cnt + FW'(1) == FAIL_MAX) begin
            state_n = LOCKED;
            timer_n = LOCK_LOAD;
            fail_n  = FAIL_MAX;
          end else begin
            fail_n = fail_cnt + FW'(1);
          end
        end else if (u_rise) begin
          state_n = OPEN;
          timer_n = OPEN_LOAD;
          fail_n  = '0;
        end
      end
      OPEN: begin
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - TW'(1);
      end
      LOCKED: begin
        if (timer == '0) begin
          state_n = IDLE;
          fail_n  = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the next state keeps the outputs aligned with the state they describe.
  always_comb begin
    door_open_n = (state_n == OPEN);
    lockout_n   = (state_n == LOCKED);
    accept_n    = (state_n == IDLE);
    alarm_n     = (state == IDLE) && (state_n == LOCKED);
  end

endmodule

// File: tb/tb_access_controller.sv
// Bench for access_controller: two configurations (defaults and minimal windows) driven by
// directed and random stimulus, compared each cycle with a window-counting reference model.
module tb_access_controller;

  localparam int NDUT = 2;
  localparam int MF [NDUT] = '{3, 1};
  localparam int OC [NDUT] = '{8, 1};
  localparam int LC [NDUT] = '{16, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic unlock = 1'b0;
  logic error = 1'b0;

  logic       door_open [NDUT];
  logic       lockout   [NDUT];
  logic       accept    [NDUT];
  logic       alarm     [NDUT];
  logic [1:0] fc0;
  logic       fc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  access_controller #(.MAX_FAIL(3), .OPEN_CYCLES(8), .LOCK_CYCLES(16)) dut0 (
    .clk(clk), .rst(rst), .unlock(unlock), .error(error),
    .door_open(door_open[0]), .lockout(lockout[0]), .accept(accept[0]),
    .alarm(alarm[0]), .fail_cnt(fc0)
  );

  access_controller #(.MAX_FAIL(1), .OPEN_CYCLES(1), .LOCK_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .unlock(unlock), .error(error),
    .door_open(door_open[1]), .lockout(lockout[1]), .accept(accept[1]),
    .alarm(alarm[1]), .fail_cnt(fc1)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining cycles of each window plus the failure count.
  int  m_open [NDUT];
  int  m_lock [NDUT];
  int  m_fail [NDUT];
  bit  m_alarm [NDUT];
  bit  prev_u = 1'b0;
  bit  prev_e = 1'b0;
  int  run_open [NDUT];
  int  run_lock [NDUT];
  bit  abort_open [NDUT];
  bit  abort_lock [NDUT];

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      m_open[d] = 0; m_lock[d] = 0; m_fail[d] = 0; m_alarm[d] = 0;
      run_open[d] = 0; run_lock[d] = 0; abort_open[d] = 0; abort_lock[d] = 0;
    end
  end

  always @(posedge clk) begin
    bit ur, er;
    ur = unlock && !prev_u;
    er = error && !prev_e;
    for (int d = 0; d < NDUT; d++) begin
      m_alarm[d] = 0;
      if (rst) begin
        if (run_open[d] > 0) abort_open[d] = 1;
        if (run_lock[d] > 0) abort_lock[d] = 1;
        m_open[d] = 0; m_lock[d] = 0; m_fail[d] = 0;
      end else if (m_open[d] > 0) begin
        m_open[d]--;
      end else if (m_lock[d] > 0) begin
        m_lock[d]--;
        if (m_lock[d] == 0) m_fail[d] = 0;
      end else if (er) begin
        if (m_fail[d] + 1 == MF[d]) begin
          m_lock[d] = LC[d];
          m_fail[d] = MF[d];
          m_alarm[d] = 1;
        end else begin
          m_fail[d]++;
        end
      end else if (ur) begin
        m_open[d] = OC[d];
        m_fail[d] = 0;
      end
    end
    prev_u = rst ? 1'b0 : unlock;
    prev_e = rst ? 1'b0 : error;
  end

  // Compare away from the active edge; also measure completed window lengths directly.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      string s;
      s = $sformatf("d%0d", d);
      check({s, ".door_open"}, int'(door_open[d]), int'(m_open[d] > 0));
      check({s, ".lockout"},   int'(lockout[d]),   int'(m_lock[d] > 0));
      check({s, ".accept"},    int'(accept[d]),    int'(m_open[d] == 0 && m_lock[d] == 0));
      check({s, ".alarm"},     int'(alarm[d]),     int'(m_alarm[d]));
      check({s, ".fail_cnt"},  (d == 0) ? int'(fc0) : int'(fc1), m_fail[d]);
      if (door_open[d]) run_open[d]++;
      else if (run_open[d] > 0) begin
        if (!abort_open[d]) check({s, ".open_len"}, run_open[d], OC[d]);
        run_open[d] = 0; abort_open[d] = 0;
      end
      if (lockout[d]) run_lock[d]++;
      else if (run_lock[d] > 0) begin
        if (!abort_lock[d]) check({s, ".lock_len"}, run_lock[d], LC[d]);
        run_lock[d] = 0; abort_lock[d] = 0;
      end
    end
  end

  task automatic drive(input bit u, input bit e, input bit r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      unlock = u; error = e; rst = r;
    end
  endtask

  initial begin
    drive(0, 0, 1, 2);
    drive(0, 0, 0, 2);
    // Single unlock, then idle past the window.
    drive(1, 0, 0, 1); drive(0, 0, 0, 12);
    // Two errors then an unlock.
    drive(0, 1, 0, 1); drive(0, 0, 0, 2);
    drive(0, 1, 0, 1); drive(0, 0, 0, 2);
    drive(1, 0, 0, 1); drive(0, 0, 0, 12);
    // Three errors to lockout, with pulses inside the lockout window.
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 1); drive(0, 0, 0, 2); end
    drive(1, 0, 0, 1); drive(0, 0, 0, 2); drive(0, 1, 0, 1); drive(0, 0, 0, 20);
    // Pulses inside OPEN, then unlock held across the end of OPEN.
    drive(1, 0, 0, 1); drive(0, 0, 0, 2); drive(0, 1, 0, 1); drive(0, 0, 0, 1);
    drive(1, 0, 0, 1); drive(0, 0, 0, 10);
    drive(1, 0, 0, 14); drive(0, 0, 0, 3);
    // Simultaneous edges with two failures already counted.
    drive(0, 1, 0, 1); drive(0, 0, 0, 2); drive(0, 1, 0, 1); drive(0, 0, 0, 2);
    drive(1, 1, 0, 1); drive(0, 0, 0, 20);
    // Reset in the middle of OPEN and of LOCKED.
    drive(1, 0, 0, 1); drive(0, 0, 0, 3); drive(0, 0, 1, 1); drive(0, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 1); drive(0, 0, 0, 1); end
    drive(0, 0, 0, 3); drive(0, 0, 1, 1); drive(0, 0, 0, 3);
    // Input already high when reset releases.
    drive(1, 0, 1, 2); drive(1, 0, 0, 3); drive(0, 0, 0, 10);
    // Back-to-back unlocks separated by one low cycle.
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 1); drive(0, 0, 0, 1); end
    drive(0, 0, 0, 12);
    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 199) == 0, 1);
    drive(0, 0, 0, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
